hps_io_initiator: RTL
=====================

// Module: hps_io_initiator
// PURPOSE
// Host-side initiator for the HPS<->core word bus (io_din/io_clk/io_uio/io_fpga/io_osd out, io_ack/io_dout/io_wide in).
// Converts a valid/ready stream of 16-bit words into four-phase io_clk/io_ack transfers and returns io_dout per word.
// Used as the HPS stand-in for core simulation and as the bus master in the on-chip test harness.
// One transaction is one enable-qualified burst: first word = command, later words = payload.
// PARAMETERS
// SETUP_CYCLES  4     clk_sys cycles io_din/enable held stable before io_clk rises (covers 2-stage gp_out sync)
// GAP_CYCLES    4     cycles all enables held low between transactions (core clears has_cmd)
// ACK_TIMEOUT   1024  max cycles waiting on any io_ack edge before abort
// PORTS
// clk_sys    in   1   system clock, single clock domain
// reset      in   1   synchronous, active-high
// req_valid  in   1   request word available
// req_ready  out  1   word accepted when req_valid & req_ready
// req_target in   2   0=uio 1=fpga 2=osd 3=reserved(no enable); sampled on first word only
// req_last   in   1   word is final of transaction
// req_wdata  in   16  word to drive on io_din
// rsp_valid  out  1   one-cycle pulse: rsp_rdata valid
// rsp_rdata  out  16  io_dout captured at ack
// err        out  1   one-cycle pulse on ack timeout
// busy       out  1   state != IDLE
// io_din     out  16  bus data
// io_clk     out  1   transfer strobe
// io_uio     out  1   user-I/O enable
// io_fpga    out  1   FPGA-I/O enable
// io_osd     out  1   OSD enable
// io_ack     in   1   core acknowledge
// io_dout    in   16  core read data
// io_wide    in   1   1=16-bit bus, 0=8-bit
// BEHAVIOUR
// Reset: state IDLE; all outputs 0 (req_ready=0 during reset cycle). Reset mid-transfer drops io_clk/enables next edge, no err.
// States: IDLE, SETUP, HIGH, LOW, NEXT, DRAIN, GAP.
// IDLE: req_ready=1. On accept, latch target/wdata/last; next cycle enable(target)=1, io_din=wdata, go SETUP.
// SETUP: count SETUP_CYCLES cycles with io_clk=0, then io_clk=1, go HIGH.
// HIGH: wait io_ack==1. On that cycle: rsp_rdata<=io_dout (bits[15:8]=0 if io_wide=0), rsp_valid pulse, io_clk<=0, go LOW.
// LOW: wait io_ack==0; then go GAP if last, else NEXT.
// NEXT: enable held, req_ready=1; on accept latch wdata/last (req_target ignored), go SETUP.
// GAP: all enables 0, io_din=0, hold GAP_CYCLES cycles, go IDLE.
// io_wide=0: io_din[15:8] driven 0.
// Timeout: counter cleared on entering HIGH/LOW, increments each cycle there. At ACK_TIMEOUT: err pulse, io_clk=0,
//   enables=0; go GAP if latched last=1, else DRAIN.
// DRAIN: req_ready=1, discard words, no bus activity, no rsp; on accepted req_last go GAP.
// Target 3: full handshake sequence runs with no enable asserted (core ignores; times out -> err).
// req_ready is 0 in SETUP/HIGH/LOW/GAP; at most one word is in flight.
// Min per-word latency, accept to rsp_valid: 1 + SETUP_CYCLES + core ack latency.
// TESTING
// 1) cfg write: target=0, words 0x0001,0x0065(last); core model ack 3 cycles -> io_uio high over both words,
//    two io_clk pulses, io_din 0x0001 then 0x0065 stable >=4 cycles before each rise, uio low 4 cycles after.
// 2) Read: io_dout=0xBEEF, io_wide=1 -> rsp_rdata=0xBEEF; io_wide=0 -> rsp_rdata=0x00EF, io_din[15:8]=0.
// 3) Timeout: core never acks, 3-word burst -> err at 1024 cycles in HIGH, io_clk/enables 0, words 2-3 drained,
//    then IDLE; no rsp_valid.
// 4) Backpressure: req_valid low 20 cycles between words -> io_osd stays high in NEXT, no extra io_clk pulse.
// 5) Reset asserted in HIGH -> next edge io_clk=0, enables=0, busy=0, err=0; new transaction completes normally.
// 6) Core model with io_wait slow ack (50 cycles) -> no timeout, exactly one rsp_valid per word, in order.

Source files
------------

// File: rtl/hps_io_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hps_io_initiator: valid/ready word stream to four-phase HPS io bus master |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hps_io_initiator #(
  parameter int SETUP_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_target,
  input  logic        req_last,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        err,
  output logic        busy,
  output logic [15:0] io_din,
  output logic        io_clk,
  output logic        io_uio,
  output logic        io_fpga,
  output logic        io_osd,
  input  logic        io_ack,
  input  logic [15:0] io_dout,
  input  logic        io_wide
);

  localparam int c_cnt_max =
    (ACK_TIMEOUT > SETUP_CYCLES) ?
      ((ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES) :
      ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES);
  localparam int c_cnt_w = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_ack_last   = c_cnt_w'(ACK_TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_zero   = '0;
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_NEXT  = 3'd4,
    S_DRAIN = 3'd5,
    S_GAP   = 3'd6
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [1:0]           r_target;
  logic                 r_last;
  logic                 r_act;
  logic [15:0]          r_din;
  logic                 r_io_clk;
  logic                 r_rsp_valid;
  logic [15:0]          r_rsp_rdata;
  logic                 r_err;

  state_t               w_state;
  logic [c_cnt_w-1:0]   w_cnt;
  logic [1:0]           w_target;
  logic                 w_last;
  logic                 w_act;
  logic [15:0]          w_din;
  logic                 w_io_clk;
  logic                 w_rsp_valid;
  logic [15:0]          w_rsp_rdata;
  logic                 w_err;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_timeout;

  always_comb begin
    w_ready = (r_state == S_IDLE) || (r_state == S_NEXT) || (r_state == S_DRAIN);
  end

  assign req_ready = w_ready & ~reset;
  assign w_accept  = req_valid & req_ready;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_target    = r_target;
    w_last      = r_last;
    w_act       = r_act;
    w_din       = r_din;
    w_io_clk    = r_io_clk;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_err       = 1'b0;
    w_timeout   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_target = req_target;
          w_din    = req_wdata;
          w_last   = req_last;
          w_act    = 1'b1;
          w_cnt    = c_cnt_zero;
          w_state  = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == c_setup_last) begin
          w_io_clk = 1'b1;
          w_cnt    = c_cnt_zero;
          w_state  = S_HIGH;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      S_HIGH: begin
        if (io_ack) begin
          w_rsp_rdata = {io_wide ? io_dout[15:8] : 8'h00, io_dout[7:0]};
          w_rsp_valid = 1'b1;
          w_io_clk    = 1'b0;
          w_cnt       = c_cnt_zero;
          w_state     = S_LOW;
        end else if (r_cnt == c_ack_last) begin
          w_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      S_LOW: begin
        if (!io_ack) begin
          w_cnt = c_cnt_zero;
          if (r_last) begin
            w_act   = 1'b0;
            w_din   = 16'h0000;
            w_state = S_GAP;
          end else begin
            w_state = S_NEXT;
          end
        end else if (r_cnt == c_ack_last) begin
          w_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      S_NEXT: begin
        // Enable stays up so the core keeps treating this as one command.
        if (w_accept) begin
          w_din   = req_wdata;
          w_last  = req_last;
          w_cnt   = c_cnt_zero;
          w_state = S_SETUP;
        end
      end
      S_DRAIN: begin
        if (w_accept && req_last) begin
          w_cnt   = c_cnt_zero;
          w_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_cnt   = c_cnt_zero;
          w_state = S_IDLE;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Abort: the rest of the burst is swallowed unless this word was the last.
    if (w_timeout) begin
      w_err    = 1'b1;
      w_io_clk = 1'b0;
      w_act    = 1'b0;
      w_din    = 16'h0000;
      w_cnt    = c_cnt_zero;
      w_state  = r_last ? S_GAP : S_DRAIN;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_target    <= 2'd0;
      r_last      <= 1'b0;
      r_act       <= 1'b0;
      r_din       <= 16'h0000;
      r_io_clk    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'h0000;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_target    <= w_target;
      r_last      <= w_last;
      r_act       <= w_act;
      r_din       <= w_din;
      r_io_clk    <= w_io_clk;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_err       <= w_err;
    end
  end

  assign io_din    = {io_wide ? r_din[15:8] : 8'h00, r_din[7:0]};
  assign io_clk    = r_io_clk;
  assign io_uio    = r_act & (r_target == 2'd0);
  assign io_fpga   = r_act & (r_target == 2'd1);
  assign io_osd    = r_act & (r_target == 2'd2);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign err       = r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
